// File: rtl/input_port_router_if.sv
// rtl/input_port_router_if.sv - packet-in, head-packet-out and select/grant bundle of one router input port
interface input_port_router_if #(
    parameter int NET_ADDR_W  = 4,
    parameter int BANK_ADDR_W = 8,
    parameter int DATA_W      = 32
);
    logic [NET_ADDR_W+BANK_ADDR_W-1:0] destinationAddressIn;
    logic [NET_ADDR_W-1:0]             requesterAddressIn;
    logic                              readIn;
    logic                              writeIn;
    logic [DATA_W-1:0]                 dataIn;
    logic                              inReady;

    logic selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST, selectBit_LOCAL;
    logic grant_NORTH, grant_SOUTH, grant_EAST, grant_WEST, grant_LOCAL;

    logic [NET_ADDR_W+BANK_ADDR_W-1:0] destinationAddressOut;
    logic [NET_ADDR_W-1:0]             requesterAddressOut;
    logic                              readOut;
    logic                              writeOut;
    logic [DATA_W-1:0]                 dataOut;

    logic overflowError;
    logic protocolError;

    modport slave (
        input  destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn,
        input  grant_NORTH, grant_SOUTH, grant_EAST, grant_WEST, grant_LOCAL,
        output inReady,
        output selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST, selectBit_LOCAL,
        output destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut,
        output overflowError, protocolError
    );

    modport master (
        output destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn,
        output grant_NORTH, grant_SOUTH, grant_EAST, grant_WEST, grant_LOCAL,
        input  inReady,
        input  selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST, selectBit_LOCAL,
        input  destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut,
        input  overflowError, protocolError
    );
endinterface

// File: rtl/input_port_router.sv
// rtl/input_port_router.sv - mesh router input port: FIFO, head register, XY route, select-until-grant
module input_port_router #(
    parameter int                    NET_ADDR_W  = 4,
    parameter int                    BANK_ADDR_W = 8,
    parameter int                    DATA_W      = 32,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [NET_ADDR_W-1:0] LOCAL_ADDR  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input_port_router_if.slave port
);
    localparam int DA_W  = NET_ADDR_W + BANK_ADDR_W;
    localparam int PKT_W = DA_W + NET_ADDR_W + 2 + DATA_W;
    localparam int HALF  = NET_ADDR_W / 2;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [HALF-1:0] LOCAL_X = LOCAL_ADDR[HALF-1:0];
    localparam logic [NET_ADDR_W-HALF-1:0] LOCAL_Y = LOCAL_ADDR[NET_ADDR_W-1:HALF];

    typedef enum logic {EMPTY, ROUTED} state_t;

    // Select vector order: {NORTH, SOUTH, EAST, WEST, LOCAL}
    function automatic logic [4:0] route(input logic [NET_ADDR_W-1:0] node);
        logic [HALF-1:0]            x;
        logic [NET_ADDR_W-HALF-1:0] y;
        x = node[HALF-1:0];
        y = node[NET_ADDR_W-1:HALF];
        if (x > LOCAL_X)      route = 5'b00100;
        else if (x < LOCAL_X) route = 5'b00010;
        else if (y > LOCAL_Y) route = 5'b01000;
        else if (y < LOCAL_Y) route = 5'b10000;
        else                  route = 5'b00001;
    endfunction

    state_t            state_q, state_d;
    logic [PKT_W-1:0]  head_q, head_d;
    logic [4:0]        sel_q, sel_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d, proto_q, proto_d;
    logic [PKT_W-1:0]  mem_q [FIFO_DEPTH];

    logic [PKT_W-1:0]  in_pkt, fifo_head;
    logic [4:0]        grant_v;
    logic              valid, both, in_ready, accept, fifo_empty, granted, load, push, pop;

    assign in_pkt     = {port.destinationAddressIn, port.requesterAddressIn,
                         port.readIn, port.writeIn, port.dataIn};
    assign fifo_head  = mem_q[rd_ptr_q];
    assign grant_v    = {port.grant_NORTH, port.grant_SOUTH, port.grant_EAST,
                         port.grant_WEST, port.grant_LOCAL};
    assign valid      = port.readIn | port.writeIn;
    assign both       = port.readIn & port.writeIn;
    assign in_ready   = (count_q != DEPTH_C);
    assign accept     = valid & ~both & in_ready;
    assign fifo_empty = (count_q == '0);
    assign granted    = |(sel_q & grant_v);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        sel_d   = sel_q;
        load    = 1'b0;
        case (state_q)
            EMPTY:   load = 1'b1;
            ROUTED:  load = granted;
            default: load = 1'b1;
        endcase
        // FIFO contents are older than the input, so they win the head slot; bypass only when empty.
        if (load) begin
            if (!fifo_empty) begin
                head_d  = fifo_head;
                sel_d   = route(fifo_head[PKT_W-1 -: NET_ADDR_W]);
                state_d = ROUTED;
            end else if (accept) begin
                head_d  = in_pkt;
                sel_d   = route(port.destinationAddressIn[DA_W-1 -: NET_ADDR_W]);
                state_d = ROUTED;
            end else begin
                head_d  = '0;
                sel_d   = '0;
                state_d = EMPTY;
            end
        end
    end

    assign pop  = load & ~fifo_empty;
    assign push = accept & ~(load & fifo_empty);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q | (valid & ~in_ready);
        proto_d  = proto_q | both;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            proto_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            sel_q    <= sel_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            proto_q  <= proto_d;
        end
    end

    // Storage is not reset; the pointers and count alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_pkt;
    end

    assign port.inReady               = in_ready;
    assign port.selectBit_NORTH       = sel_q[4];
    assign port.selectBit_SOUTH       = sel_q[3];
    assign port.selectBit_EAST        = sel_q[2];
    assign port.selectBit_WEST        = sel_q[1];
    assign port.selectBit_LOCAL       = sel_q[0];
    assign port.destinationAddressOut = head_q[PKT_W-1 -: DA_W];
    assign port.requesterAddressOut   = head_q[DATA_W+2 +: NET_ADDR_W];
    assign port.readOut               = head_q[DATA_W+1];
    assign port.writeOut              = head_q[DATA_W];
    assign port.dataOut               = head_q[DATA_W-1:0];
    assign port.overflowError         = ovf_q;
    assign port.protocolError         = proto_q;
endmodule

// File: tb/tb_input_port_router.sv
// tb/tb_input_port_router.sv - directed self-checking bench for input_port_router
module tb_input_port_router;
    localparam logic [4:0] SEL_N = 5'b10000, SEL_S = 5'b01000, SEL_E = 5'b00100,
                           SEL_W = 5'b00010, SEL_L = 5'b00001, SEL_0 = 5'b00000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    input_port_router_if #(.NET_ADDR_W(4), .BANK_ADDR_W(8), .DATA_W(32)) bus ();

    input_port_router #(
        .NET_ADDR_W(4), .BANK_ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(4), .LOCAL_ADDR(4'h5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .port  (bus.slave)
    );

    always #5 clk = ~clk;

    logic [4:0] sel_v;
    assign sel_v = {bus.selectBit_NORTH, bus.selectBit_SOUTH, bus.selectBit_EAST,
                    bus.selectBit_WEST, bus.selectBit_LOCAL};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_grants(input logic [4:0] g);
        {bus.grant_NORTH, bus.grant_SOUTH, bus.grant_EAST, bus.grant_WEST, bus.grant_LOCAL} = g;
    endtask

    task automatic send(input logic [3:0] node, input logic [7:0] bank, input logic [3:0] req,
                        input logic [31:0] data, input logic rd, input logic wr);
        bus.destinationAddressIn = {node, bank};
        bus.requesterAddressIn   = req;
        bus.dataIn               = data;
        bus.readIn               = rd;
        bus.writeIn              = wr;
        step();
        bus.readIn  = 1'b0;
        bus.writeIn = 1'b0;
    endtask

    logic [3:0]  nodes [4];
    logic [4:0]  exp_sel [4];

    initial begin
        nodes   = '{4'h4, 4'h1, 4'h9, 4'h5};
        exp_sel = '{SEL_W, SEL_N, SEL_S, SEL_L};
        reset = 1'b1;
        bus.destinationAddressIn = '0;
        bus.requesterAddressIn   = '0;
        bus.readIn  = 1'b0;
        bus.writeIn = 1'b0;
        bus.dataIn  = '0;
        set_grants(SEL_0);
        step();
        step();
        chk("reset_inready", bus.inReady, 1);
        chk("reset_sel", sel_v, SEL_0);
        chk("reset_errors", {bus.overflowError, bus.protocolError}, 0);
        chk("reset_fields", {bus.readOut, bus.writeOut, bus.dataOut, bus.destinationAddressOut}, 0);
        #2 reset = 1'b0;
        step();

        // 1: write toward node 7 from node 5 routes EAST one cycle after acceptance
        send(4'h7, 8'h10, 4'h3, 32'hCAFE_0001, 1'b0, 1'b1);
        chk("t1_sel", sel_v, SEL_E);
        chk("t1_dest", bus.destinationAddressOut, 12'h710);
        chk("t1_req", bus.requesterAddressOut, 4'h3);
        chk("t1_data", bus.dataOut, 32'hCAFE_0001);
        chk("t1_rw", {bus.readOut, bus.writeOut}, 2'b01);
        set_grants(SEL_E);
        step();
        set_grants(SEL_0);
        chk("t1_retired", sel_v, SEL_0);

        // 2: WEST, NORTH, SOUTH, LOCAL; a stray grant must not retire the head
        for (int i = 0; i < 4; i++) begin
            send(nodes[i], 8'h20, 4'h1, 32'h1000 + i, 1'b1, 1'b0);
            chk($sformatf("t2_sel%0d", i), sel_v, exp_sel[i]);
            set_grants(~exp_sel[i]);
            step();
            chk($sformatf("t2_stray%0d", i), sel_v, exp_sel[i]);
            set_grants(exp_sel[i]);
            step();
            set_grants(SEL_0);
            chk($sformatf("t2_ret%0d", i), sel_v, SEL_0);
        end

        // 3: five packets fill head+FIFO, the sixth overflows, then drain in order
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_ready%0d", i), bus.inReady, (i < 5) ? 1 : 0);
            send(4'h7, 8'h30, 4'h2, 32'h3000 + i, 1'b0, 1'b1);
        end
        chk("t3_overflow", bus.overflowError, 1);
        set_grants(SEL_E);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_order%0d", i), bus.dataOut, 32'h3000 + i);
            step();
        end
        set_grants(SEL_0);
        chk("t3_drained", sel_v, SEL_0);

        // 4: packet every cycle with grant held: new head each cycle, no stall
        set_grants(SEL_E);
        for (int i = 0; i < 6; i++) begin
            send(4'h7, 8'h40, 4'h4, 32'h4000 + i, 1'b0, 1'b1);
            chk($sformatf("t4_head%0d", i), bus.dataOut, 32'h4000 + i);
            chk($sformatf("t4_ready%0d", i), bus.inReady, 1);
        end
        step();
        set_grants(SEL_0);
        chk("t4_empty", sel_v, SEL_0);

        // 5: read+write together is dropped and flagged stickily
        chk("t5_proto_before", bus.protocolError, 0);
        send(4'h7, 8'h50, 4'h5, 32'h5000, 1'b1, 1'b1);
        chk("t5_sel", sel_v, SEL_0);
        chk("t5_proto", bus.protocolError, 1);
        step();
        step();
        chk("t5_proto_sticky", bus.protocolError, 1);

        // 6: async reset with head + 3 queued while granting
        for (int i = 0; i < 4; i++) send(4'h7, 8'h60, 4'h6, 32'h6000 + i, 1'b0, 1'b1);
        chk("t6_queued_ready", bus.inReady, 1);
        set_grants(SEL_E);
        #2 reset = 1'b1;
        #1;
        chk("t6_sel", sel_v, SEL_0);
        chk("t6_ready", bus.inReady, 1);
        chk("t6_errors", {bus.overflowError, bus.protocolError}, 0);
        chk("t6_fields", {bus.writeOut, bus.dataOut}, 0);
        set_grants(SEL_0);
        #1 reset = 1'b0;
        send(4'h4, 8'h70, 4'h7, 32'h7777, 1'b1, 1'b0);
        chk("t6_after_sel", sel_v, SEL_W);
        chk("t6_after_data", bus.dataOut, 32'h7777);
        set_grants(SEL_W);
        step();
        set_grants(SEL_0);
        chk("t6_after_empty", sel_v, SEL_0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
